// File: rtl/mole_pkg.sv
// Shared types and sizing for the whack-a-mole spawner: state encoding,
// counter/timer widths and the length of the random-draw window.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        GAP,
        UP
    } state_e;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMER_W     = 10;
    localparam int unsigned DRAW_CYCLES = 3;
    localparam int unsigned DRAW_CNT_W  = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a bank of debounced button levels.
module btn_edge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole game core: draws a random mole, waits a gap, lights it for a
// random up-time and scores hits/misses with saturating counters.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned NUM_MOLES = 8,
    parameter int unsigned MIN_UP    = 200,
    parameter int unsigned GAP_TICKS = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [15:0]          rnd,
    input  logic [NUM_MOLES-1:0] hit_btn,
    output logic                 shift_en,
    output logic [NUM_MOLES-1:0] mole_on,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_MOLES);
    localparam logic [TIMER_W-1:0] MIN_UP_T = TIMER_W'(MIN_UP);
    localparam logic [TIMER_W-1:0] GAP_LAST =
        (GAP_TICKS == 0) ? '0 : TIMER_W'(GAP_TICKS - 1);
    localparam logic [DRAW_CNT_W-1:0] DRAW_LAST = DRAW_CNT_W'(DRAW_CYCLES - 1);

    state_e                 state_q,      state_d;
    logic [DRAW_CNT_W-1:0]  draw_cnt_q,   draw_cnt_d;
    logic [TIMER_W-1:0]     timer_q,      timer_d;
    logic [TIMER_W-1:0]     up_time_q,    up_time_d;
    logic [IDX_W-1:0]       idx_q,        idx_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   shift_en_q,   shift_en_d;
    logic [NUM_MOLES-1:0]   mole_on_q,    mole_on_d;
    logic                   hit_pulse_q,  hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]       hit_cnt_q,    hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q,   miss_cnt_d;

    logic [NUM_MOLES-1:0]   rise;
    logic [IDX_W-1:0]       draw_idx;
    logic                   up_last;
    logic                   hit_now;
    logic                   unused_rnd;

    btn_edge #(.WIDTH(NUM_MOLES)) u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (hit_btn),
        .rise_o (rise)
    );

    assign unused_rnd = ^rnd[7:IDX_W];

    // Never light the same hole twice in a row.
    always_comb begin
        draw_idx = rnd[IDX_W-1:0];
        if (prev_valid_q && (draw_idx == idx_q)) begin
            draw_idx = draw_idx + IDX_W'(1);
        end
    end

    assign up_last = ({1'b0, timer_q} + (TIMER_W + 1)'(1)) >= {1'b0, up_time_q};
    assign hit_now = rise[idx_q];

    always_comb begin
        state_d      = state_q;
        draw_cnt_d   = draw_cnt_q;
        timer_d      = timer_q;
        up_time_d    = up_time_q;
        idx_d        = idx_q;
        prev_valid_d = prev_valid_q;
        shift_en_d   = 1'b0;
        mole_on_d    = mole_on_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            IDLE: begin
                mole_on_d = '0;
                if (start) begin
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                    draw_cnt_d = '0;
                    shift_en_d = 1'b1;
                    state_d    = DRAW;
                end
            end

            DRAW: begin
                if (draw_cnt_q == DRAW_LAST) begin
                    idx_d        = draw_idx;
                    prev_valid_d = 1'b1;
                    up_time_d    = MIN_UP_T + TIMER_W'(rnd[15:8]);
                    timer_d      = '0;
                    if (GAP_TICKS == 0) begin
                        mole_on_d = NUM_MOLES'(1) << draw_idx;
                        state_d   = UP;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    draw_cnt_d = draw_cnt_q + DRAW_CNT_W'(1);
                end
            end

            GAP: begin
                if (tick) begin
                    if (timer_q == GAP_LAST) begin
                        timer_d   = '0;
                        mole_on_d = NUM_MOLES'(1) << idx_q;
                        state_d   = UP;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end

            UP: begin
                // A hit edge wins over a coinciding final tick.
                if (hit_now) begin
                    mole_on_d   = '0;
                    hit_pulse_d = 1'b1;
                    hit_cnt_d   = sat_inc(hit_cnt_q);
                    draw_cnt_d  = '0;
                    shift_en_d  = 1'b1;
                    state_d     = DRAW;
                end else if (tick && up_last) begin
                    mole_on_d    = '0;
                    miss_pulse_d = 1'b1;
                    miss_cnt_d   = sat_inc(miss_cnt_q);
                    draw_cnt_d   = '0;
                    shift_en_d   = 1'b1;
                    state_d      = DRAW;
                end else if (tick) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                mole_on_d = '0;
                state_d   = IDLE;
            end
        endcase

        // Dropping start aborts the round silently but keeps the score.
        if (!start) begin
            state_d      = IDLE;
            mole_on_d    = '0;
            shift_en_d   = 1'b0;
            hit_pulse_d  = 1'b0;
            miss_pulse_d = 1'b0;
            hit_cnt_d    = hit_cnt_q;
            miss_cnt_d   = miss_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            draw_cnt_q   <= '0;
            timer_q      <= '0;
            up_time_q    <= '0;
            idx_q        <= '0;
            prev_valid_q <= 1'b0;
            shift_en_q   <= 1'b0;
            mole_on_q    <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            draw_cnt_q   <= draw_cnt_d;
            timer_q      <= timer_d;
            up_time_q    <= up_time_d;
            idx_q        <= idx_d;
            prev_valid_q <= prev_valid_d;
            shift_en_q   <= shift_en_d;
            mole_on_q    <= mole_on_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign mole_on    = mole_on_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: stimulus queues expected output events,
// a negedge monitor pops and compares each one the DUT presents.
module tb_mole_spawner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rnd = '0;
    logic [7:0]  hit_btn = '0;
    logic        shift_en, hit_pulse, miss_pulse;
    logic [7:0]  mole_on, hit_count, miss_count;

    always #5 clk = ~clk;

    mole_spawner #(
        .NUM_MOLES (8),
        .MIN_UP    (4),
        .GAP_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .rnd        (rnd),
        .hit_btn    (hit_btn),
        .shift_en   (shift_en),
        .mole_on    (mole_on),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        string      nm;
        logic       sh;
        logic       hi;
        logic       mi;
        logic [7:0] mo;
        logic [7:0] hc;
        logic [7:0] mc;
        int         dt;   // cycles since previous event, 0 = don't care
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    logic [7:0] last_mole = '0;
    logic       prev_hit = 1'b0, prev_miss = 1'b0, prev_shift = 1'b0;

    task automatic push(input string nm, input logic sh, input logic hi, input logic mi,
                        input logic [7:0] mo, input logic [7:0] hc, input logic [7:0] mc,
                        input int dt);
        ev_t e;
        e.nm = nm; e.sh = sh; e.hi = hi; e.mi = mi;
        e.mo = mo; e.hc = hc; e.mc = mc; e.dt = dt;
        exp_q.push_back(e);
    endtask

    // Monitor: an event is any strobe or any change of the lamp word.
    always @(negedge clk) begin
        ev_t e;
        int  dt;
        cyc++;
        if (!rst) begin
            n_checks++;
            if ((hit_pulse && miss_pulse) || (hit_pulse && prev_hit) ||
                (miss_pulse && prev_miss) || (shift_en && prev_shift)) begin
                n_fail++;
                $display("FAIL pulse_rules: got hit=%0b miss=%0b shift=%0b (prev %0b%0b%0b), want no overlap or repeat",
                         hit_pulse, miss_pulse, shift_en, prev_hit, prev_miss, prev_shift);
            end
            if (shift_en || hit_pulse || miss_pulse || (mole_on != last_mole)) begin
                dt = cyc - last_cyc;
                last_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got sh=%0b hit=%0b miss=%0b mole=%02h hits=%0d misses=%0d, want no event",
                             shift_en, hit_pulse, miss_pulse, mole_on, hit_count, miss_count);
                end else begin
                    e = exp_q.pop_front();
                    if (shift_en !== e.sh || hit_pulse !== e.hi || miss_pulse !== e.mi ||
                        mole_on !== e.mo || hit_count !== e.hc || miss_count !== e.mc ||
                        (e.dt != 0 && dt != e.dt)) begin
                        n_fail++;
                        $display("FAIL %s: got sh=%0b hit=%0b miss=%0b mole=%02h hits=%0d misses=%0d dt=%0d, want sh=%0b hit=%0b miss=%0b mole=%02h hits=%0d misses=%0d dt=%0d",
                                 e.nm, shift_en, hit_pulse, miss_pulse, mole_on, hit_count, miss_count, dt,
                                 e.sh, e.hi, e.mi, e.mo, e.hc, e.mc, e.dt);
                    end
                end
            end
        end
        prev_hit   = hit_pulse;
        prev_miss  = miss_pulse;
        prev_shift = shift_en;
        last_mole  = mole_on;
    end

    task automatic check_idle(input string nm, input logic [7:0] hc, input logic [7:0] mc);
        n_checks++;
        if (shift_en !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 ||
            mole_on !== 8'h00 || hit_count !== hc || miss_count !== mc) begin
            n_fail++;
            $display("FAIL %s: got sh=%0b hit=%0b miss=%0b mole=%02h hits=%0d misses=%0d, want all quiet hits=%0d misses=%0d",
                     nm, shift_en, hit_pulse, miss_pulse, mole_on, hit_count, miss_count, hc, mc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        hit_btn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state", 8'd0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d events still pending after %0d cycles, want 0",
                     nm, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] pidx;
        logic [2:0] idx;
        bit         pval;
        logic [7:0] mc;

        do_reset();

        // Basic timeout: idx 5, up_time 4+3=7.
        rnd = 16'h0305;
        start = 1'b1;
        push("r33_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("r33_up",    0, 0, 0, 8'h20, 0, 0, 5);
        push("r33_miss",  1, 0, 1, 8'h00, 0, 1, 7);
        drain("r33", 40);
        do_reset();

        // Repeat-index avoidance.
        rnd = 16'h0005;
        start = 1'b1;
        push("r34a_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("r34a_up1",   0, 0, 0, 8'h20, 0, 0, 5);
        push("r34a_miss",  1, 0, 1, 8'h00, 0, 1, 4);
        push("r34a_up2",   0, 0, 0, 8'h40, 0, 1, 5);
        drain("r34a", 40);
        do_reset();

        rnd = 16'h0007;
        start = 1'b1;
        push("r34b_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("r34b_up1",   0, 0, 0, 8'h80, 0, 0, 5);
        push("r34b_miss",  1, 0, 1, 8'h00, 0, 1, 4);
        push("r34b_wrap",  0, 0, 0, 8'h01, 0, 1, 5);
        drain("r34b", 40);
        do_reset();

        // Hit on the third up tick.
        rnd = 16'h0305;
        start = 1'b1;
        push("r35_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("r35_up",    0, 0, 0, 8'h20, 0, 0, 5);
        push("r35_hit",   1, 1, 0, 8'h00, 1, 0, 3);
        repeat (8) @(posedge clk);
        #1 hit_btn = 8'h20;
        drain("r35", 40);
        do_reset();

        // Wrong button ignored; hit edge on the final tick counts as hit only.
        rnd = 16'h0305;
        start = 1'b1;
        push("r36_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("r36_up",    0, 0, 0, 8'h20, 0, 0, 5);
        push("r36_hit",   1, 1, 0, 8'h00, 1, 0, 7);
        repeat (7) @(posedge clk);
        #1 hit_btn = 8'h01;
        repeat (5) @(posedge clk);
        #1 hit_btn = 8'h21;
        drain("r36", 40);
        do_reset();

        // 300 timeouts, miss counter saturates; then drop start while up.
        rnd = 16'h0005;
        start = 1'b1;
        pval = 1'b0;
        pidx = '0;
        push("r37_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        for (int k = 1; k <= 301; k++) begin
            idx = rnd[2:0];
            if (pval && idx == pidx) idx = idx + 3'd1;
            pidx = idx;
            pval = 1'b1;
            mc = (k > 255) ? 8'd255 : 8'(k - 1);
            push("r37_up", 0, 0, 0, 8'h01 << idx, 0, mc, 5);
            if (k <= 300) begin
                mc = (k >= 255) ? 8'd255 : 8'(k);
                push("r37_miss", 1, 0, 1, 8'h00, 0, mc, 4);
            end
        end
        drain("r37_run", 300 * 9 + 50);
        start = 1'b0;
        push("r37_stop", 0, 0, 0, 8'h00, 0, 255, 1);
        drain("r37_stop", 10);
        repeat (3) @(negedge clk);
        check_idle("r37_idle_kept", 8'd0, 8'd255);
        do_reset();

        // Reset in the middle of UP overrides start.
        rnd = 16'h0305;
        start = 1'b1;
        push("rst_shift", 1, 0, 0, 8'h00, 0, 0, 0);
        push("rst_up1",   0, 0, 0, 8'h20, 0, 0, 5);
        push("rst_miss",  1, 0, 1, 8'h00, 0, 1, 7);
        push("rst_up2",   0, 0, 0, 8'h40, 0, 1, 5);
        drain("rst_pre", 40);
        push("rst_mid",   0, 0, 0, 8'h00, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        drain("rst_mid", 10);
        check_idle("rst_mid_outputs", 8'd0, 8'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
